// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: decodes PS/2 make/break/E0 sequences from the keyboard FIFO into key events (E0 decoding enabled by PS2_SCAN_EXT_EN).
module ps2_scan_ctrl #(
  parameter int COUNT_W       = 8,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ps2_data,
  input  logic               ps2_ready,
  input  logic               ps2_overflow,
  output logic               ps2_nextdata_n,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_break,
  output logic               evt_ext,
  output logic               held_valid,
  output logic [7:0]         held_code,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_sticky
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_n;
  logic pop, mk, bk, ext, held_ext, sup;
  assign pop = ps2_ready & ~evt_valid & ~rst;
  assign ps2_nextdata_n = ~pop;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    mk = 1'b0;
    bk = 1'b0;
    ext = 1'b0;
    if (pop) begin
`ifdef PS2_SCAN_EXT_EN
      case (state)
        IDLE: begin
          if (ps2_data == 8'hE0) state_n = EXT;
          else if (ps2_data == 8'hF0) state_n = BRK;
          else mk = 1'b1;
        end
        EXT: begin
          ext = 1'b1;
          if (ps2_data == 8'hF0) state_n = EXT_BRK;
          else if (ps2_data != 8'hE0) begin
            mk = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          bk = 1'b1;
          state_n = IDLE;
        end
        default: begin
          bk = 1'b1;
          ext = 1'b1;
          state_n = IDLE;
        end
      endcase
`else
      // Without extended decoding, E0 prefixes are swallowed wherever they appear.
      if (ps2_data != 8'hE0) begin
        if (state == BRK) begin
          bk = 1'b1;
          state_n = IDLE;
        end else if (ps2_data == 8'hF0) state_n = BRK;
        else mk = 1'b1;
      end
`endif
    end
  end
  assign sup = REPEAT_FILTER && held_valid && held_code == ps2_data && held_ext == ext;
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid   <= 1'b0;
      evt_code    <= 8'h00;
      evt_break   <= 1'b0;
      evt_ext     <= 1'b0;
      held_valid  <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_count <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      if (evt_valid && evt_ready) evt_valid <= 1'b0;
      if ((mk && !sup) || bk) begin
        evt_valid <= 1'b1;
        evt_code  <= ps2_data;
        evt_break <= bk;
        evt_ext   <= ext;
      end
      if (mk && !sup) begin
        held_valid  <= 1'b1;
        held_code   <= ps2_data;
        held_ext    <= ext;
        press_count <= press_count + COUNT_W'(1);
      end
      if (bk && held_valid && held_code == ps2_data && held_ext == ext) held_valid <= 1'b0;
      if (ps2_overflow) ovf_sticky <= 1'b1;
    end
  end
endmodule
